// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master/responder control blocks:
// CONTROL/STATUS bit positions and the frame state encoding.
package spi_pkg;

    // CONTROL register bit positions
    localparam int CTRL_EN        = 0;
    localparam int CTRL_CPOL      = 1;
    localparam int CTRL_CPHA      = 2;
    localparam int CTRL_LSB_FIRST = 3;
    localparam int CTRL_RX_IRQ    = 4;
    localparam int CTRL_TX_IRQ    = 5;
    localparam int CTRL_ERR_IRQ   = 6;
    localparam int CTRL_CLR_ERR   = 7;

    // STATUS register bit positions (bit 6 is reserved and reads 0)
    localparam int STAT_RX_FULL   = 0;
    localparam int STAT_TX_FULL   = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_UNDERRUN  = 3;
    localparam int STAT_BUSY      = 4;
    localparam int STAT_FRAME_ERR = 5;
    localparam int STAT_CS_SYNC   = 7;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for an asynchronous input with single-cycle
// rise/fall pulses derived from the synchronised value.
module spi_sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Synchroniser chain plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_slave_control.sv
// SPI responder controller: oversamples SCK/CS/MOSI, shifts frames through
// single-entry TX/RX buffers and reports overrun/underrun/frame errors.
module spi_slave_control
    import spi_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH    = 8,
    parameter int unsigned           SYNC_STAGES   = 2,
    parameter logic [DATA_WIDTH-1:0] UNDERRUN_FILL = '1
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic                  SCK,
    input  logic                  CS,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic                  MISO_OE,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  WRITE,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    input  logic                  READ,
    input  logic [7:0]            CONTROL,
    output logic [7:0]            STATUS,
    output logic                  IRQ
);

    localparam int unsigned           CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]      LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    spi_state_e state_q, state_d;

    logic sck_sync, sck_rise, sck_fall;
    logic cs_sync, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi_s;

    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] tx_sr_q, rx_sr_q, tx_buf_q, rx_buf_q;
    logic                  tx_full_q, rx_full_q;
    logic                  overrun_q, underrun_q, frame_err_q;
    logic                  miso_q, miso_oe_q, irq_q;

    logic en, cpol, cpha, lsb_first, clr_err;
    logic sck_edge, leading, trailing, sample_edge, shift_edge;
    logic do_load, do_abort, do_sample, do_shift, frame_done;
    logic [DATA_WIDTH-1:0] rx_frame, load_word;
    logic overrun_set, underrun_set, frame_err_set;

    assign en        = CONTROL[CTRL_EN];
    assign cpol      = CONTROL[CTRL_CPOL];
    assign cpha      = CONTROL[CTRL_CPHA];
    assign lsb_first = CONTROL[CTRL_LSB_FIRST];
    assign clr_err   = CONTROL[CTRL_CLR_ERR];

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clk   (CLK),
        .rst_n (CLR),
        .d     (SCK),
        .q     (sck_sync),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk   (CLK),
        .rst_n (CLR),
        .d     (CS),
        .q     (cs_sync),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // MOSI only needs the synchroniser, no edge detection
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        end
    end
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // An edge is leading when it leaves the idle (CPOL) level
    assign sck_edge    = sck_rise | sck_fall;
    assign leading     = sck_edge & (sck_sync ^ cpol);
    assign trailing    = sck_edge & ~(sck_sync ^ cpol);
    assign sample_edge = cpha ? trailing : leading;
    assign shift_edge  = cpha ? leading : trailing;

    assign rx_frame  = lsb_first ? {mosi_s, rx_sr_q[DATA_WIDTH-1:1]}
                                 : {rx_sr_q[DATA_WIDTH-2:0], mosi_s};
    assign load_word = tx_full_q ? tx_buf_q : UNDERRUN_FILL;

    // State register
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle frame actions
    always_comb begin
        state_d    = state_q;
        do_load    = 1'b0;
        do_abort   = 1'b0;
        do_sample  = 1'b0;
        do_shift   = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en && cs_fall) state_d = LOAD;
            end
            LOAD: begin
                if (cs_rise || !en) begin
                    do_abort = 1'b1;
                    state_d  = IDLE;
                end else begin
                    do_load = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise || !en) begin
                    do_abort = 1'b1;
                    state_d  = IDLE;
                end else begin
                    if (sample_edge) begin
                        do_sample = 1'b1;
                        if (cnt_q == LAST_BIT) begin
                            frame_done = 1'b1;
                            state_d    = LOAD;
                        end
                    end
                    // Bit 0 is already on MISO, so no advance before the first sample
                    if (shift_edge && cnt_q != '0) do_shift = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign overrun_set   = frame_done & rx_full_q & ~READ;
    assign underrun_set  = do_load & ~tx_full_q;
    assign frame_err_set = do_abort & (state_q == SHIFT) & (cnt_q != '0);

    // Shift datapath, buffers and MISO
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            cnt_q     <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
        end else begin
            if (do_load) begin
                cnt_q     <= '0;
                tx_sr_q   <= load_word;
                miso_q    <= lsb_first ? load_word[0] : load_word[DATA_WIDTH-1];
                miso_oe_q <= 1'b1;
            end else if (do_abort) begin
                miso_oe_q <= 1'b0;
            end
            if (do_sample) begin
                cnt_q   <= cnt_q + CNT_W'(1);
                rx_sr_q <= rx_frame;
            end
            if (do_shift) begin
                if (lsb_first) begin
                    tx_sr_q <= {1'b0, tx_sr_q[DATA_WIDTH-1:1]};
                    miso_q  <= tx_sr_q[1];
                end else begin
                    tx_sr_q <= {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
                    miso_q  <= tx_sr_q[DATA_WIDTH-2];
                end
            end
        end
    end

    // Host-side buffers, sticky errors and registered IRQ
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            tx_buf_q    <= '0;
            tx_full_q   <= 1'b0;
            rx_buf_q    <= '0;
            rx_full_q   <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            // A WRITE coinciding with LOAD of an empty buffer waits for the next frame
            if (do_load && tx_full_q) begin
                tx_full_q <= 1'b0;
            end else if (WRITE && !tx_full_q) begin
                tx_buf_q  <= DATA_IN;
                tx_full_q <= 1'b1;
            end
            if (frame_done && (!rx_full_q || READ)) begin
                rx_buf_q  <= rx_frame;
                rx_full_q <= 1'b1;
            end else if (READ) begin
                rx_full_q <= 1'b0;
            end
            if (overrun_set)       overrun_q <= 1'b1;
            else if (clr_err)      overrun_q <= 1'b0;
            if (underrun_set)      underrun_q <= 1'b1;
            else if (clr_err)      underrun_q <= 1'b0;
            if (frame_err_set)     frame_err_q <= 1'b1;
            else if (clr_err)      frame_err_q <= 1'b0;
            irq_q <= (rx_full_q & CONTROL[CTRL_RX_IRQ])
                   | (~tx_full_q & CONTROL[CTRL_TX_IRQ])
                   | ((overrun_q | underrun_q | frame_err_q) & CONTROL[CTRL_ERR_IRQ]);
        end
    end

    // STATUS assembly
    always_comb begin
        STATUS                 = '0;
        STATUS[STAT_RX_FULL]   = rx_full_q;
        STATUS[STAT_TX_FULL]   = tx_full_q;
        STATUS[STAT_OVERRUN]   = overrun_q;
        STATUS[STAT_UNDERRUN]  = underrun_q;
        STATUS[STAT_BUSY]      = (state_q != IDLE);
        STATUS[STAT_FRAME_ERR] = frame_err_q;
        STATUS[STAT_CS_SYNC]   = cs_sync;
    end

    assign MISO     = miso_q;
    assign MISO_OE  = miso_oe_q;
    assign DATA_OUT = rx_buf_q;
    assign IRQ      = irq_q;

endmodule

// File: tb/tb_spi_slave_control.sv
// Self-checking bench: behavioural SPI master plus scoreboard queues of the
// words the master should receive and the words DATA_OUT should show.
module tb_spi_slave_control;

    logic       CLK = 1'b0;
    logic       CLR, SCK, CS, MOSI, MISO, MISO_OE, WRITE, READ, IRQ;
    logic [7:0] DATA_IN, DATA_OUT, CONTROL, STATUS;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic       m_cpol, m_cpha, m_lsb;
    logic [7:0] exp_miso_q[$];
    logic [7:0] exp_rx_q[$];

    spi_slave_control #(.DATA_WIDTH(8), .SYNC_STAGES(2), .UNDERRUN_FILL(8'hFF)) dut (
        .CLK      (CLK),
        .CLR      (CLR),
        .SCK      (SCK),
        .CS       (CS),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .MISO_OE  (MISO_OE),
        .DATA_IN  (DATA_IN),
        .WRITE    (WRITE),
        .DATA_OUT (DATA_OUT),
        .READ     (READ),
        .CONTROL  (CONTROL),
        .STATUS   (STATUS),
        .IRQ      (IRQ)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic set_ctrl(input logic [7:0] c);
        @(negedge CLK);
        CONTROL = c;
        m_cpol  = c[1];
        m_cpha  = c[2];
        m_lsb   = c[3];
        SCK     = c[1];
        cycles(4);
    endtask

    task automatic host_write(input logic [7:0] d);
        @(negedge CLK);
        DATA_IN = d;
        WRITE   = 1'b1;
        @(negedge CLK);
        WRITE   = 1'b0;
    endtask

    task automatic host_read();
        @(negedge CLK);
        READ = 1'b1;
        @(negedge CLK);
        READ = 1'b0;
    endtask

    task automatic clear_errors();
        @(negedge CLK);
        CONTROL[7] = 1'b1;
        cycles(2);
        CONTROL[7] = 1'b0;
    endtask

    task automatic cs_low();
        CS = 1'b0;
        #100;
    endtask

    task automatic cs_high();
        #80;
        CS = 1'b1;
        cycles(6);
    endtask

    // Master side of nbits bit periods; SCK half period is 8 CLK
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        int idx;
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            idx = m_lsb ? i : 7 - i;
            if (!m_cpha) begin
                MOSI = tx[idx];
                #80;
                SCK = ~m_cpol;
                rx[idx] = MISO;
                #80;
                SCK = m_cpol;
            end else begin
                SCK  = ~m_cpol;
                MOSI = tx[idx];
                #80;
                SCK = m_cpol;
                rx[idx] = MISO;
                #80;
            end
        end
    endtask

    task automatic frame(input string tag, input logic [7:0] master_tx,
                         input logic [7:0] exp_master_rx);
        logic [7:0] got;
        exp_miso_q.push_back(exp_master_rx);
        xfer(master_tx, 8, got);
        check(tag, {24'h0, got}, {24'h0, exp_miso_q.pop_front()});
    endtask

    task automatic check_data_out(input string tag);
        check(tag, {24'h0, DATA_OUT}, {24'h0, exp_rx_q.pop_front()});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] junk;
        logic       seen;
        CLR = 1'b0; SCK = 1'b0; CS = 1'b1; MOSI = 1'b0;
        WRITE = 1'b0; READ = 1'b0; DATA_IN = 8'h00; CONTROL = 8'h00;
        m_cpol = 1'b0; m_cpha = 1'b0; m_lsb = 1'b0;
        cycles(3);
        check("rst_status", {24'h0, STATUS}, 32'h80);
        check("rst_miso_oe", {31'h0, MISO_OE}, 32'h0);
        check("rst_miso", {31'h0, MISO}, 32'h0);
        check("rst_data_out", {24'h0, DATA_OUT}, 32'h0);
        check("rst_irq", {31'h0, IRQ}, 32'h0);
        CLR = 1'b1;
        cycles(3);

        // Mode 0, MSB first
        set_ctrl(8'h01);
        host_write(8'hA5);
        check("m0_tx_full", {31'h0, STATUS[1]}, 32'h1);
        cs_low();
        frame("m0_miso_word", 8'h3C, 8'hA5);
        cs_high();
        exp_rx_q.push_back(8'h3C);
        check("m0_rx_full", {31'h0, STATUS[0]}, 32'h1);
        check("m0_tx_empty", {31'h0, STATUS[1]}, 32'h0);
        check_data_out("m0_data_out");
        check("m0_idle", {31'h0, STATUS[4]}, 32'h0);
        host_read();
        check("m0_read_clears", {31'h0, STATUS[0]}, 32'h0);
        check("m0_data_hold", {24'h0, DATA_OUT}, 32'h3C);
        clear_errors();

        // Modes 1..3, LSB first
        for (int m = 1; m < 4; m++) begin
            set_ctrl({4'b0000, 1'b1, m[0], m[1], 1'b1});
            host_write(8'h81);
            cs_low();
            frame($sformatf("mode%0d_miso_word", m), 8'h96, 8'h81);
            cs_high();
            exp_rx_q.push_back(8'h96);
            check_data_out($sformatf("mode%0d_data_out", m));
            host_read();
            clear_errors();
        end

        // Underrun + overrun with two back-to-back frames
        set_ctrl(8'h01);
        check("ur_clean", {30'h0, STATUS[3:2]}, 32'h0);
        cs_low();
        frame("ur_word0", 8'h11, 8'hFF);
        frame("ur_word1", 8'h22, 8'hFF);
        cs_high();
        exp_rx_q.push_back(8'h11);
        check("ur_underrun", {31'h0, STATUS[3]}, 32'h1);
        check("ur_overrun", {31'h0, STATUS[2]}, 32'h1);
        check("ur_rx_full", {31'h0, STATUS[0]}, 32'h1);
        check_data_out("ur_data_out");
        clear_errors();
        check("ur_cleared", {30'h0, STATUS[3:2]}, 32'h0);

        // Frame error: CS rises after 3 SCK edges, RX buffer still full
        cs_low();
        SCK = 1'b1; #80;
        SCK = 1'b0; #80;
        SCK = 1'b1; #80;
        CS = 1'b1;
        cycles(6);
        SCK = 1'b0;
        check("fe_frame_err", {31'h0, STATUS[5]}, 32'h1);
        check("fe_rx_full", {31'h0, STATUS[0]}, 32'h1);
        check("fe_data_out", {24'h0, DATA_OUT}, 32'h11);
        check("fe_miso_oe", {31'h0, MISO_OE}, 32'h0);
        check("fe_busy", {31'h0, STATUS[4]}, 32'h0);
        clear_errors();
        host_read();
        check("fe_cleared", {31'h0, STATUS[5]}, 32'h0);

        // Reset mid-frame, then a clean frame
        host_write(8'h5A);
        cs_low();
        xfer(8'hFF, 5, junk);
        check("rr_busy_before", {31'h0, STATUS[4]}, 32'h1);
        CLR = 1'b0;
        #1;
        check("rr_status", {24'h0, STATUS}, 32'h80);
        check("rr_miso_oe", {31'h0, MISO_OE}, 32'h0);
        CS = 1'b1; SCK = 1'b0; MOSI = 1'b0;
        cycles(3);
        CLR = 1'b1;
        cycles(4);
        host_write(8'hC3);
        cs_low();
        frame("rr_miso_word", 8'h69, 8'hC3);
        cs_high();
        exp_rx_q.push_back(8'h69);
        check_data_out("rr_data_out");
        host_read();
        clear_errors();

        // IRQ on RX full
        set_ctrl(8'h11);
        check("irq_idle", {31'h0, IRQ}, 32'h0);
        host_write(8'h5E);
        seen = 1'b0;
        fork
            begin
                cs_low();
                frame("irq_miso_word", 8'hA7, 8'h5E);
                cs_high();
            end
            begin
                for (int i = 0; i < 3000 && !seen; i++) begin
                    @(negedge CLK);
                    if (STATUS[0]) seen = 1'b1;
                end
                check("irq_rx_seen", {31'h0, seen}, 32'h1);
                check("irq_lag0", {31'h0, IRQ}, 32'h0);
                @(negedge CLK);
                check("irq_rise", {31'h0, IRQ}, 32'h1);
            end
        join
        exp_rx_q.push_back(8'hA7);
        check_data_out("irq_data_out");
        @(negedge CLK);
        READ = 1'b1;
        @(negedge CLK);
        READ = 1'b0;
        check("irq_read_rx", {31'h0, STATUS[0]}, 32'h0);
        check("irq_still_hi", {31'h0, IRQ}, 32'h1);
        @(negedge CLK);
        check("irq_fall", {31'h0, IRQ}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
